// File: rtl/vga_plot_sequencer_if.sv
// Bus bundle between the phase sequencer, its plotting clients, the
// vga_adapter and the controlling logic. The sequencer uses the master view.
`timescale 1ns/1ps

interface vga_plot_sequencer_if #(
    parameter int N_CLIENTS = 2
);
    localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    // control
    logic                     go;
    logic                     restart;
    logic [N_CLIENTS-1:0]     skip_mask;

    // client handshake and plot buses
    logic [N_CLIENTS-1:0]     client_start;
    logic [N_CLIENTS-1:0]     client_waitrequest;
    logic [N_CLIENTS-1:0]     client_vga_plot;
    logic [8*N_CLIENTS-1:0]   client_vga_x;
    logic [7*N_CLIENTS-1:0]   client_vga_y;
    logic [3*N_CLIENTS-1:0]   client_vga_colour;

    // arbitrated port to vga_adapter
    logic                     vga_plot;
    logic [7:0]               vga_x;
    logic [6:0]               vga_y;
    logic [2:0]               vga_colour;

    // status
    logic [PW-1:0]            phase;
    logic                     busy;
    logic                     done;
    logic [N_CLIENTS-1:0]     timeout_err;

    modport master (
        input  go, restart, skip_mask,
        input  client_waitrequest, client_vga_plot, client_vga_x, client_vga_y, client_vga_colour,
        output client_start,
        output vga_plot, vga_x, vga_y, vga_colour,
        output phase, busy, done, timeout_err
    );

    modport slave (
        output go, restart, skip_mask,
        output client_waitrequest, client_vga_plot, client_vga_x, client_vga_y, client_vga_colour,
        input  client_start,
        input  vga_plot, vga_x, vga_y, vga_colour,
        input  phase, busy, done, timeout_err
    );
endinterface

// File: rtl/vga_plot_sequencer.sv
// Phase sequencer and VGA-port arbiter for the 160x120 frame-buffer path.
// Runs the plotting clients in index order (skipping masked ones), hands the
// VGA port to the client owning the active phase, and guards each phase with
// an optional watchdog that records sticky per-phase timeout flags.
`timescale 1ns/1ps

module vga_plot_sequencer #(
    parameter int N_CLIENTS      = 2,
    parameter int RESIDENT_LAST  = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_plot_sequencer_if.master  bus
);
    localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam logic [N_CLIENTS-1:0] ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_RUN, S_DONE} state_t;

    state_t               state;
    logic [PW-1:0]        phase_q;
    logic [N_CLIENTS-1:0] start_q;
    logic                 busy_q;
    logic                 done_q;
    logic [N_CLIENTS-1:0] err_q;
    logic [31:0]          wd_cnt;

    logic                 first_ok, next_ok;
    logic [PW-1:0]        first_idx, next_idx;
    state_t               ent_state, adv_state;
    logic [PW-1:0]        ent_phase, adv_phase;
    logic [N_CLIENTS-1:0] ent_start, adv_start;
    logic                 wait_cur, resident_now, wd_fire, advance;

    // Phase selection and the targets of a sequence start or a phase advance
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        first_ok  = 1'b0;
        first_idx = '0;
        next_ok   = 1'b0;
        next_idx  = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (!bus.skip_mask[i]) begin
                first_ok  = 1'b1;
                first_idx = PW'(i);
                if (i > int'(phase_q)) begin
                    next_ok  = 1'b1;
                    next_idx = PW'(i);
                end
            end
        end

        ent_state = first_ok ? S_ISSUE : S_DONE;
        ent_phase = first_ok ? first_idx : '0;
        ent_start = first_ok ? (ONE << first_idx) : '0;
        adv_state = next_ok ? S_ISSUE : S_DONE;
        adv_phase = next_ok ? next_idx : phase_q;
        adv_start = next_ok ? (ONE << next_idx) : '0;

        wait_cur     = bus.client_waitrequest[phase_q];
        resident_now = (RESIDENT_LAST != 0) && (phase_q == PW'(N_CLIENTS - 1));
        // a resident last phase is only watched until its command is accepted
        wd_fire      = (TIMEOUT_CYCLES != 0)
                       && (state inside {S_ISSUE, S_ARM, S_RUN})
                       && !(resident_now && state != S_ISSUE)
                       && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
        advance      = wd_fire || (state == S_RUN && !resident_now && !wait_cur);
    end

    // Sequencer FSM with registered start, phase, status and watchdog state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            phase_q <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            wd_cnt  <= '0;
        end else if (bus.restart) begin
            // start is held low for this first ISSUE cycle, then reissued
            state   <= ent_state;
            phase_q <= ent_phase;
            start_q <= '0;
            busy_q  <= (ent_state == S_ISSUE);
            done_q  <= (ent_state == S_DONE);
            err_q   <= '0;
            wd_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.go) begin
                        // NOTE: state updates use <= so every register samples pre-edge values.
                        state   <= ent_state;
                        phase_q <= ent_phase;
                        start_q <= ent_start;
                        busy_q  <= (ent_state == S_ISSUE);
                        done_q  <= (ent_state == S_DONE);
                        err_q   <= '0;
                        wd_cnt  <= '0;
                    end
                end
                S_ISSUE, S_ARM, S_RUN: begin
                    wd_cnt <= advance ? '0 : wd_cnt + 32'd1;
                    if (wd_fire) err_q[phase_q] <= 1'b1;
                    if (advance) begin
                        state   <= adv_state;
                        phase_q <= adv_phase;
                        start_q <= adv_start;
                        busy_q  <= (adv_state == S_ISSUE);
                        done_q  <= (adv_state == S_DONE);
                    end else if (state == S_ISSUE) begin
                        if (start_q == '0) begin
                            start_q <= ONE << phase_q;
                        end else if (!wait_cur) begin
                            state   <= S_ARM;
                            start_q <= '0;
                        end
                    end else if (state == S_ARM) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Zero-latency VGA mux: only the owning client drives the port in ARM/RUN
    always_comb begin
        bus.vga_plot   = 1'b0;
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        if (state == S_ARM || state == S_RUN) begin
            bus.vga_plot   = bus.client_vga_plot[phase_q];
            bus.vga_x      = bus.client_vga_x[8*int'(phase_q) +: 8];
            bus.vga_y      = bus.client_vga_y[7*int'(phase_q) +: 7];
            bus.vga_colour = bus.client_vga_colour[3*int'(phase_q) +: 3];
        end
    end

    assign bus.client_start = start_q;
    assign bus.phase        = phase_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.timeout_err  = err_q;

endmodule

// File: tb/tb_vga_plot_sequencer.sv
// Directed bench for vga_plot_sequencer: three configurations share one clock
// and reset; expected values are hand-computed cycle by cycle.
`timescale 1ns/1ps

module tb_vga_plot_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // A: two phases, resident last, no watchdog
    vga_plot_sequencer_if #(.N_CLIENTS(2)) ia ();
    vga_plot_sequencer #(.N_CLIENTS(2), .RESIDENT_LAST(1), .TIMEOUT_CYCLES(0))
        dut_a (.clk(clk), .rst(rst), .bus(ia));

    // B: three phases, last phase completes normally
    vga_plot_sequencer_if #(.N_CLIENTS(3)) ib ();
    vga_plot_sequencer #(.N_CLIENTS(3), .RESIDENT_LAST(0), .TIMEOUT_CYCLES(0))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    // C: two phases with a 20-cycle watchdog
    vga_plot_sequencer_if #(.N_CLIENTS(2)) ic ();
    vga_plot_sequencer #(.N_CLIENTS(2), .RESIDENT_LAST(0), .TIMEOUT_CYCLES(20))
        dut_c (.clk(clk), .rst(rst), .bus(ic));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic saw_b1;

        ia.go = 1'b0; ia.restart = 1'b0; ia.skip_mask = '0;
        ia.client_waitrequest = '0; ia.client_vga_plot = '0;
        ia.client_vga_x = '0; ia.client_vga_y = '0; ia.client_vga_colour = '0;
        ib.go = 1'b0; ib.restart = 1'b0; ib.skip_mask = '0;
        ib.client_waitrequest = '0; ib.client_vga_plot = '0;
        ib.client_vga_x = '0; ib.client_vga_y = '0; ib.client_vga_colour = '0;
        ic.go = 1'b0; ic.restart = 1'b0; ic.skip_mask = '0;
        ic.client_waitrequest = '0; ic.client_vga_plot = '0;
        ic.client_vga_x = '0; ic.client_vga_y = '0; ic.client_vga_colour = '0;

        // reset state
        #12;
        check("rst_phase",  32'(ia.phase), 32'd0);
        check("rst_busy",   32'(ia.busy), 32'd0);
        check("rst_done",   32'(ia.done), 32'd0);
        check("rst_start",  32'(ia.client_start), 32'd0);
        check("rst_err",    32'(ic.timeout_err), 32'd0);
        tick();
        rst = 1'b0;

        // ---------------- two-phase default run (A) ----------------
        ia.client_vga_plot   = 2'b01;
        ia.client_vga_x      = {8'd0, 8'd10};
        ia.client_vga_y      = {7'd0, 7'd5};
        ia.client_vga_colour = {3'd0, 3'd3};
        check("a_idle_vga_plot", 32'(ia.vga_plot), 32'd0);
        check("a_idle_vga_x",    32'(ia.vga_x), 32'd0);
        ia.go = 1'b1;
        tick();                                  // ISSUE phase 0
        ia.go = 1'b0;
        check("a_issue_start", 32'(ia.client_start), 32'b01);
        check("a_issue_busy",  32'(ia.busy), 32'd1);
        check("a_issue_vga",   32'(ia.vga_plot), 32'd0);
        tick();                                  // accepted -> ARM
        check("a_arm_start",  32'(ia.client_start), 32'd0);
        check("a_arm_plot",   32'(ia.vga_plot), 32'd1);
        check("a_arm_x",      32'(ia.vga_x), 32'd10);
        check("a_arm_y",      32'(ia.vga_y), 32'd5);
        check("a_arm_colour", 32'(ia.vga_colour), 32'd3);
        ia.client_waitrequest = 2'b01;           // client busy for 50 cycles
        for (int c = 0; c < 50; c++) tick();
        check("a_run0_phase", 32'(ia.phase), 32'd0);
        check("a_run0_busy",  32'(ia.busy), 32'd1);
        check("a_run0_x",     32'(ia.vga_x), 32'd10);
        ia.client_waitrequest = 2'b00;
        ia.client_vga_x       = {8'd77, 8'd10};
        ia.client_vga_y       = {7'd100, 7'd5};
        ia.client_vga_colour  = {3'd5, 3'd3};
        tick();                                  // ISSUE phase 1
        check("a_issue1_phase", 32'(ia.phase), 32'd1);
        check("a_issue1_start", 32'(ia.client_start), 32'b10);
        check("a_issue1_x",     32'(ia.vga_x), 32'd0);
        tick();                                  // ARM phase 1
        check("a_arm1_x",      32'(ia.vga_x), 32'd77);
        check("a_arm1_y",      32'(ia.vga_y), 32'd100);
        check("a_arm1_colour", 32'(ia.vga_colour), 32'd5);
        check("a_arm1_plot",   32'(ia.vga_plot), 32'd0);
        for (int c = 0; c < 10; c++) tick();     // resident: stays in RUN
        check("a_res_busy",  32'(ia.busy), 32'd1);
        check("a_res_done",  32'(ia.done), 32'd0);
        check("a_res_phase", 32'(ia.phase), 32'd1);
        check("a_res_x",     32'(ia.vga_x), 32'd77);

        // ---------------- restart in resident phase (A) ----------------
        ia.restart = 1'b1;
        tick();
        ia.restart = 1'b0;
        check("rs_vga_x",  32'(ia.vga_x), 32'd0);
        check("rs_plot",   32'(ia.vga_plot), 32'd0);
        check("rs_gap",    32'(ia.client_start), 32'd0);
        check("rs_phase",  32'(ia.phase), 32'd0);
        tick();
        check("rs_start",  32'(ia.client_start), 32'b01);
        tick();                                  // ARM phase 0
        ia.client_waitrequest = 2'b01;
        tick();                                  // RUN phase 0, plotting
        check("rs_run_plot", 32'(ia.vga_plot), 32'd1);

        // ---------------- skip (B) ----------------
        ib.skip_mask = 3'b010;
        ib.go = 1'b1;
        tick();                                  // edge 1: ISSUE phase 0
        ib.go = 1'b0;
        check("b_p0_phase", 32'(ib.phase), 32'd0);
        check("b_p0_start", 32'(ib.client_start), 32'b001);
        saw_b1 = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            tick();
            saw_b1 |= ib.client_start[1];
            if (c == 4) begin
                check("b_p2_phase", 32'(ib.phase), 32'd2);
                check("b_p2_start", 32'(ib.client_start), 32'b100);
            end
            if (c == 6) check("b_p2_done_early", 32'(ib.done), 32'd0);
        end
        check("b_done",     32'(ib.done), 32'd1);
        check("b_busy",     32'(ib.busy), 32'd0);
        check("b_no_start1", 32'(saw_b1), 32'd0);

        // ---------------- all skipped (B) ----------------
        ib.skip_mask = 3'b111;
        ib.go = 1'b1;
        tick();
        ib.go = 1'b0;
        check("all_done", 32'(ib.done), 32'd1);
        check("all_busy", 32'(ib.busy), 32'd0);
        check("all_start", 32'(ib.client_start), 32'd0);
        tick();
        check("all_busy2", 32'(ib.busy), 32'd0);

        // ---------------- watchdog (C) ----------------
        ic.client_waitrequest = 2'b01;           // client 0 never accepts
        ic.go = 1'b1;
        tick();                                  // cycle 1 in phase 0
        ic.go = 1'b0;
        check("wd_start0", 32'(ic.client_start), 32'b01);
        for (int c = 0; c < 19; c++) tick();     // 20 cycles in phase 0
        check("wd_err_early", 32'(ic.timeout_err), 32'd0);
        check("wd_phase_early", 32'(ic.phase), 32'd0);
        tick();                                  // watchdog fires
        check("wd_err",    32'(ic.timeout_err), 32'b01);
        check("wd_phase",  32'(ic.phase), 32'd1);
        check("wd_start1", 32'(ic.client_start), 32'b10);
        tick();                                  // ARM
        tick();                                  // RUN
        tick();                                  // DONE
        check("wd_done",   32'(ic.done), 32'd1);
        check("wd_sticky", 32'(ic.timeout_err), 32'b01);
        ic.client_waitrequest = 2'b00;
        ic.go = 1'b1;
        tick();
        ic.go = 1'b0;
        check("wd_go_clear", 32'(ic.timeout_err), 32'd0);
        check("wd_go_start", 32'(ic.client_start), 32'b01);

        // ---------------- async reset mid-RUN (A) ----------------
        check("ar_pre_plot", 32'(ia.vga_plot), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("ar_plot",   32'(ia.vga_plot), 32'd0);
        check("ar_x",      32'(ia.vga_x), 32'd0);
        check("ar_y",      32'(ia.vga_y), 32'd0);
        check("ar_colour", 32'(ia.vga_colour), 32'd0);
        check("ar_busy",   32'(ia.busy), 32'd0);
        check("ar_phase",  32'(ia.phase), 32'd0);
        check("ar_start_c", 32'(ic.client_start), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_plot_sequencer.md
# vga_plot_sequencer

Parametrised phase sequencer and VGA-port arbiter for the 160x120 frame-buffer path. It runs up to N plotting clients in fixed order, for example init screen, then splash, then game plot. Each client is started with a start/waitrequest handshake, and only the client owning the active phase drives vga_plot/x/y/colour. Beyond a fixed two-phase sequencer it adds a per-phase skip mask, an optional resident last phase, restart without global reset, and a per-phase watchdog with sticky error flags.

## Interface
- N_CLIENTS, 2: number of client phases, 1..8; phase width PW = max(1, clog2(N_CLIENTS)).
- RESIDENT_LAST, 1: 1 = last phase keeps the VGA port forever once accepted; 0 = it completes like the others.
- TIMEOUT_CYCLES, 0: per-phase watchdog limit in cycles; 0 disables. Counter is 32 bits.
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  asynchronous, active-high reset.
- go  in  1  one-cycle request to start the sequence; honoured in IDLE and DONE only.
- restart  in  1  abort the sequence and restart from the first enabled phase; honoured in any state, priority over go.
- skip_mask  in  N_CLIENTS  bit i = 1 skips phase i; sampled at each phase selection.
- client_start  out  N_CLIENTS  start to client i.
- client_waitrequest  in  N_CLIENTS  client i busy/not-ready.
- client_vga_plot  in  N_CLIENTS  client plot strobes.
- client_vga_x  in  8*N_CLIENTS  packed, client i at [8i+7:8i].
- client_vga_y  in  7*N_CLIENTS  packed, client i at [7i+6:7i].
- client_vga_colour  in  3*N_CLIENTS  packed, client i at [3i+2:3i].
- vga_plot / vga_x / vga_y / vga_colour  out  1 / 8 / 7 / 3  to vga_adapter.
- phase  out  PW  index of the active phase; 0 when IDLE.
- busy  out  1  high in ISSUE, ARM, RUN.
- done  out  1  high in DONE.
- timeout_err  out  N_CLIENTS  sticky; bit i set when phase i's watchdog fires.

## Operation
- States: IDLE, ISSUE, ARM, RUN, DONE.
- **Phase selection.** "Next phase" is the lowest index greater than the current phase with skip_mask = 0. "First phase" is the lowest index with skip_mask = 0. If no such phase exists, go to DONE.
- **IDLE / DONE.**
  - go -> ISSUE at the first phase.
  - If every phase is skipped, go -> DONE on the next cycle.
- **ISSUE.**
  - client_start[phase] = 1.
  - client_waitrequest[phase] = 0 means the command is accepted -> ARM.
- **ARM.** One guard cycle. Start is 0 and waitrequest is ignored, which lets the client raise waitrequest. Then -> RUN.
- **RUN.**
  - client_waitrequest[phase] = 0 means the phase is complete -> ISSUE at the next phase, or DONE if there is none.
  - Exception: if RESIDENT_LAST = 1 and phase = N_CLIENTS-1, stay in RUN indefinitely and ignore waitrequest.
- **VGA mux.** In ARM and RUN, the vga_* outputs equal client[phase]'s signals, combinationally with zero latency. In all other states every vga_* output is 0. Other clients' inputs are ignored.
- **Watchdog.**
  - The counter clears on phase entry and increments each cycle in ISSUE/ARM/RUN.
  - When TIMEOUT_CYCLES ≠ 0 and the count equals TIMEOUT_CYCLES-1:
    - set timeout_err[phase];
    - drop start;
    - advance exactly as a completion would.
  - The watchdog is disabled for a resident last phase once it reaches ARM.
- **restart.**
  - All client_start go to 0 for one cycle. Next state is ISSUE at the first phase, or DONE if all are skipped.
  - timeout_err clears. go also clears timeout_err when honoured.
  - A running client is not aborted. Its ISSUE waits for that client's waitrequest = 0.
- **Simultaneous events.**
  - restart + go: restart wins.
  - go outside IDLE/DONE: ignored.
  - A skip_mask change mid-phase affects only later selections.

## Timing
- **Reset values:** state IDLE, phase 0, client_start 0, busy 0, done 0, timeout_err 0, all vga_* 0, counter 0.
- **Registered outputs:** client_start, phase, busy, done and timeout_err are decoded from registered state. Only the vga_* outputs are combinational from client inputs.
- **Latency:** go at edge k gives client_start high from cycle k+1. Acceptance at edge m gives ARM at m+1 and RUN at m+2.
- **Minimum phase length** with an immediately accepting, single-cycle client: 3 cycles (ISSUE, ARM, RUN).
- **Reset mid-operation:** asynchronous. All outputs return to reset values immediately, without waiting for a clock edge.

## Test plan
- **Two-phase default run.** N=2, RESIDENT_LAST=1. go pulse:
  - client_start[0] rises the cycle after go; ARM follows acceptance.
  - client 0 holds waitrequest for 50 cycles, plotting x=10, y=5, colour=3. These values appear on vga_* only in ARM/RUN.
  - Phase 1 becomes resident; done never rises.
- **Skip.** N=3, RESIDENT_LAST=0, skip_mask=3'b010:
  - phases run 0 then 2, and client_start[1] never asserts;
  - done=1 after phase 2 completes.
- **All skipped.** skip_mask=3'b111, go: DONE on the next cycle; busy never asserts.
- **Watchdog.** TIMEOUT_CYCLES=20, client 0 never drops waitrequest:
  - timeout_err=01 after exactly 20 cycles in phase 0;
  - phase advances to 1;
  - a subsequent go clears timeout_err.
- **Restart in resident phase.** restart while phase=1:
  - vga_* go to 0;
  - client_start[0] reasserts after one idle cycle.
- **Async reset.** Assert rst mid-RUN with vga_plot=1: every output is 0 before the next clk edge.
